lmsm_sequencer: RTL and testbench

- Multi-cycle sequencer for the load-multiple and store-multiple instructions.
- The main controller hands it a base address, an 8-bit register mask and a direction. It then walks the mask from R0 to R7 and performs one memory transfer per set bit over a req/ack memory handshake. Loads are written back into the register file one register at a time.
- While `busy` is high the main controller stalls; it resumes on `done`.

---
 rtl/lmsm_sequencer.sv | 145 ++++++++++++++
 tb/tb_lmsm_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lmsm_sequencer.sv
// Load/store-multiple sequencer: walks an 8-bit register mask from R0 to R7,
// issuing one req/ack memory transfer per set bit and writing loads back to the RF.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// SCAN  | pick lowest remaining mask bit, read RF for stores
// REQ   | memory request held until mem_ack
// WRITE | one-cycle RF write of the loaded word
// DONE  | one-cycle done pulse, end_addr presented
module lmsm_sequencer #(
  parameter int DW        = 16,
  parameter int AW        = 16,
  parameter int ADDR_STEP = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          is_store,
  input  logic [AW-1:0] base_addr,
  input  logic [7:0]    reg_mask,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] end_addr,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [2:0]    rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic          rf_wen,
  output logic [2:0]    rf_waddr,
  output logic [DW-1:0] rf_wdata
);

  typedef enum logic [2:0] {IDLE, SCAN, REQ, WRITE, DONE} state_t;

  state_t        state, state_nxt;
  logic          is_store_r;
  logic [AW-1:0] cur_addr, end_addr_r, addr_inc;
  logic [7:0]    rem_mask;
  logic [2:0]    idx, low_idx;
  logic [DW-1:0] wdata_r, rdata_r;

  assign addr_inc = cur_addr + AW'(ADDR_STEP);

  // Priority encoder: lowest set bit wins, giving ascending register order.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (rem_mask[i]) low_idx = 3'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    end_addr  = end_addr_r;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_raddr  = 3'd0;
    rf_wen    = 1'b0;
    rf_waddr  = 3'd0;
    rf_wdata  = '0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (reg_mask == 8'd0) ? DONE : SCAN;
      end
      SCAN: begin
        rf_raddr  = low_idx;
        state_nxt = REQ;
      end
      REQ: begin
        mem_req   = 1'b1;
        mem_we    = is_store_r;
        mem_addr  = cur_addr;
        mem_wdata = is_store_r ? wdata_r : '0;
        if (mem_ack) begin
          if (is_store_r) state_nxt = (rem_mask != 8'd0) ? SCAN : DONE;
          else            state_nxt = WRITE;
        end
      end
      WRITE: begin
        rf_wen    = 1'b1;
        rf_waddr  = idx;
        rf_wdata  = rdata_r;
        state_nxt = (rem_mask != 8'd0) ? SCAN : DONE;
      end
      DONE: begin
        done      = 1'b1;
        end_addr  = cur_addr;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_store_r <= 1'b0;
      cur_addr   <= '0;
      end_addr_r <= '0;
      rem_mask   <= 8'd0;
      idx        <= 3'd0;
      wdata_r    <= '0;
      rdata_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            is_store_r <= is_store;
            cur_addr   <= base_addr;
            rem_mask   <= reg_mask;
          end
        end
        SCAN: begin
          idx      <= low_idx;
          rem_mask <= rem_mask & (rem_mask - 8'd1);
          if (is_store_r) wdata_r <= rf_rdata;
        end
        REQ: begin
          if (mem_ack) begin
            if (is_store_r) cur_addr <= addr_inc;
            else            rdata_r  <= mem_rdata;
          end
        end
        WRITE: cur_addr <= addr_inc;
        // end_addr stays visible after done until the next operation completes
        DONE:  end_addr_r <= cur_addr;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Bench for lmsm_sequencer: table of operations checked against a transfer
// scoreboard, plus hand sequences for start-during-DONE and mid-operation reset.
module tb_lmsm_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_store;
  logic [15:0] base_addr;
  logic [7:0]  reg_mask;
  logic        busy, done;
  logic [15:0] end_addr;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        rf_wen;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;

  lmsm_sequencer #(.DW(16), .AW(16), .ADDR_STEP(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
    .base_addr(base_addr), .reg_mask(reg_mask), .busy(busy), .done(done),
    .end_addr(end_addr), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic [15:0] rf_model [8];
  assign rf_rdata = rf_model[rf_raddr];

  function automatic logic [15:0] memval(input logic [15:0] a);
    if (a == 16'h0100) return 16'hAAAA;
    if (a == 16'h0101) return 16'h5555;
    return a ^ 16'hC3C3;
  endfunction

  typedef struct {
    bit          is_rf;
    bit          we;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;

  txn_t sb[$];
  txn_t mon_t;
  int   wait_cfg = 0;
  int   wcnt = 0;
  logic spur_ack = 1'b0;

  // Memory responder and monitor: every REQ cycle is compared with the head of
  // the scoreboard (so values must hold through wait cycles); popped on ack.
  always @(negedge clk) begin
    if (rf_wen) begin
      chk("req_wen_exclusive", {31'd0, mem_req}, 32'd0);
      if (sb.size() == 0) chk("rf_unexpected_wen", {31'd0, rf_wen}, 32'd0);
      else begin
        mon_t = sb.pop_front();
        chk("rf_kind", {31'd0, mon_t.is_rf}, 32'd1);
        chk("rf_waddr", {29'd0, rf_waddr}, {16'd0, mon_t.addr});
        chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, mon_t.data});
      end
    end
    if (mem_req === 1'b1) begin
      if (sb.size() == 0) begin
        chk("mem_unexpected_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0;
      end else begin
        mon_t = sb[0];
        chk("mem_kind", {31'd0, mon_t.is_rf}, 32'd0);
        chk("mem_we", {31'd0, mem_we}, {31'd0, mon_t.we});
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, mon_t.addr});
        if (mon_t.we) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, mon_t.data});
        if (wcnt >= wait_cfg) begin
          mem_ack   = 1'b1;
          mem_rdata = memval(mem_addr);
          wcnt      = 0;
          void'(sb.pop_front());
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 16'hDEAD;
          wcnt++;
        end
      end
    end else begin
      mem_ack   = spur_ack;
      mem_rdata = 16'hDEAD;
      wcnt      = 0;
    end
  end

  // mode 1: pulse start with other operands mid-operation; mode 2: pulse start during DONE
  task automatic run_op(input bit st, input logic [15:0] base, input logic [7:0] mask,
                        input int wt, input int exp_cyc, input logic [15:0] exp_end,
                        input int mode, input string nm);
    logic [15:0] a;
    int got;
    @(negedge clk);
    wait_cfg = wt;
    a = base;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        if (st) sb.push_back('{1'b0, 1'b1, a, rf_model[i]});
        else begin
          sb.push_back('{1'b0, 1'b0, a, 16'h0});
          sb.push_back('{1'b1, 1'b0, 16'(i), memval(a)});
        end
        a = a + 16'd1;
      end
    end
    is_store = st; base_addr = base; reg_mask = mask; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    got = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (mode == 1 && c == 3) begin
        start = 1'b1; is_store = ~st; base_addr = 16'h0000; reg_mask = 8'hFF;
      end else if (mode == 1 && c == 4) start = 1'b0;
      if (done) begin got = c; break; end
    end
    chk({nm, "_done_cycle"}, got, exp_cyc);
    chk({nm, "_end_addr"}, {16'd0, end_addr}, {16'd0, exp_end});
    chk({nm, "_busy_in_done"}, {31'd0, busy}, 32'd1);
    if (mode == 2) begin
      start = 1'b1; is_store = 1'b1; base_addr = 16'h7777; reg_mask = 8'h01;
    end
    @(negedge clk);
    start = 1'b0;
    chk({nm, "_busy_after"}, {31'd0, busy}, 32'd0);
    chk({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    repeat (3) @(negedge clk);
    chk({nm, "_idle_hold"}, {31'd0, busy}, 32'd0);
    chk({nm, "_end_addr_held"}, {16'd0, end_addr}, {16'd0, exp_end});
    chk({nm, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  typedef struct {
    bit          st;
    logic [15:0] base;
    logic [7:0]  mask;
    int          wt;
    int          cyc;
    logic [15:0] end_a;
    int          mode;
  } vec_t;

  vec_t vecs [8];

  initial begin
    vecs[0] = '{1'b1, 16'h0040, 8'h05, 0,  5, 16'h0042, 0};
    vecs[1] = '{1'b0, 16'h0100, 8'h82, 0,  7, 16'h0102, 0};
    vecs[2] = '{1'b1, 16'h2000, 8'hFF, 2, 33, 16'h2008, 0};
    vecs[3] = '{1'b1, 16'h1234, 8'h00, 0,  1, 16'h1234, 0};
    vecs[4] = '{1'b0, 16'hFFFF, 8'h03, 0,  7, 16'h0001, 1};
    vecs[5] = '{1'b0, 16'h0300, 8'hFF, 1, 33, 16'h0308, 0};
    vecs[6] = '{1'b1, 16'hABCD, 8'h80, 3,  6, 16'hABCE, 2};
    vecs[7] = '{1'b0, 16'h00FF, 8'h10, 4,  8, 16'h0100, 0};

    for (int i = 0; i < 8; i++) rf_model[i] = 16'h1000 + 16'(i) * 16'h0101;
    rf_model[0] = 16'h1111;
    rf_model[2] = 16'h2222;

    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; base_addr = 16'h0; reg_mask = 8'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {28'd0, busy, done, mem_req, mem_we}, 32'd0);
    chk("reset_addr", {end_addr, mem_addr}, 32'd0);
    chk("reset_data", {mem_wdata, rf_wdata}, 32'd0);
    chk("reset_rf", {25'd0, rf_wen, rf_raddr, rf_waddr}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].st, vecs[i].base, vecs[i].mask, vecs[i].wt, vecs[i].cyc,
             vecs[i].end_a, vecs[i].mode, $sformatf("vec%0d", i));

    // Reset while a store request is waiting for ack
    @(negedge clk);
    wait_cfg = 50;
    sb.push_back('{1'b0, 1'b1, 16'h0500, rf_model[3]});
    is_store = 1'b1; base_addr = 16'h0500; reg_mask = 8'h08; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    chk("rst_pre_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
    rst_n = 1'b1;
    sb.delete();
    spur_ack = 1'b1;
    repeat (3) @(negedge clk);
    spur_ack = 1'b0;
    chk("late_ack_ignored", {30'd0, busy, mem_req}, 32'd0);
    run_op(1'b0, 16'h0040, 8'h04, 0, 4, 16'h0041, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
